// File: rtl/ld_seq_pkg.sv
// Shared definitions for the multi-cycle load/store sequencer.
// Holds the 4-bit state encoding, the decoded opcode constants and the
// pc_src mux codes used by ld_sequencer and its testbench-facing state port.
package ld_seq_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WR   = 4'd6,
    WB_ALU   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    INTR     = 4'd11,
    FAULT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_VEC    = 2'd3;

  // States that hold a memory request open until mem_rdy.
  function automatic logic is_wait_state(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/ld_wait_timer.sv
// Memory-handshake watchdog: counts wait cycles without mem_rdy.
// Latency: expired is a combinational view of the registered count.
// No backpressure; clr/inc are sampled every cycle.
// Ports: CLK, RESET (sync, active-high), clr (restart count), inc (one more
// wait cycle), expired (current cycle is the last one allowed to wait).
module ld_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // When the count already holds WAIT_MAX-1, one more cycle without mem_rdy
  // makes WAIT_MAX wait cycles, so the FSM leaves for FAULT on this edge.
  assign expired = (cnt == LAST);

endmodule

// File: rtl/ld_sequencer.sv
// Multi-cycle control sequencer for a simple load/store CPU datapath.
// Latency: R/ADDI 4, LW 5, SW 4, BEQ 3, J 3 cycles; +1 per memory wait cycle.
// Backpressure: FETCH/MEM_RD/MEM_WR stall on mem_rdy, FAULT after WAIT_MAX waits.
// Ports: CLK, RESET (sync, active-high); opcode/zero/mem_rdy/int_req inputs;
// register/memory enables, pc_src mux select, state and sticky fault outputs.
// Optional feature: define INTR_EN to enable the INTR state and int_req.
module ld_sequencer
  import ld_seq_pkg::*;
#(
  parameter int         WAIT_MAX    = 15,
  parameter logic [1:0] INT_VEC_SEL = 2'b11
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_rdy,
  input  logic       int_req,
  output logic       pc_ld,
  output logic       ir_ld,
  output logic       mdr_ld,
  output logic       aluout_ld,
  output logic       rf_we,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       epc_ld,
  output logic       int_ack,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       fault
);

  state_t st, st_nxt, st_done;
  logic   wait_clr, wait_inc, wait_exp;

  // Where a completed instruction goes; int_req is only looked at here.
`ifdef INTR_EN
  assign st_done = int_req ? INTR : FETCH;
`else
  logic unused_int_req;
  assign unused_int_req = int_req;
  assign st_done        = FETCH;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st <= FETCH;
    end else begin
      st <= st_nxt;
    end
  end

  // Counter restarts whenever a wait state is newly entered.
  assign wait_inc = is_wait_state(st) && !mem_rdy && !RESET;
  assign wait_clr = is_wait_state(st_nxt) && (st_nxt != st);

  ld_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
    .CLK     (CLK),
    .RESET   (RESET),
    .clr     (wait_clr),
    .inc     (wait_inc),
    .expired (wait_exp)
  );

  always_comb begin
    st_nxt    = st;
    pc_ld     = 1'b0;
    ir_ld     = 1'b0;
    mdr_ld    = 1'b0;
    aluout_ld = 1'b0;
    rf_we     = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    epc_ld    = 1'b0;
    int_ack   = 1'b0;
    pc_src    = PC_INC;
    case (st)
      FETCH: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          ir_ld  = 1'b1;
          pc_ld  = 1'b1;
          st_nxt = DECODE;
        end else if (wait_exp) begin
          st_nxt = FAULT;
        end
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE:     st_nxt = EXEC_R;
          OP_ADDI:      st_nxt = EXEC_I;
          OP_LW, OP_SW: st_nxt = MEM_ADDR;
          OP_BEQ:       st_nxt = BRANCH;
          OP_J:         st_nxt = JUMP;
          default:      st_nxt = FAULT;
        endcase
      end
      EXEC_R, EXEC_I: begin
        aluout_ld = 1'b1;
        st_nxt    = WB_ALU;
      end
      MEM_ADDR: begin
        // IR is stable after FETCH, so opcode still selects LW vs SW here.
        aluout_ld = 1'b1;
        if (opcode == OP_LW) begin
          st_nxt = MEM_RD;
        end else if (opcode == OP_SW) begin
          st_nxt = MEM_WR;
        end else begin
          st_nxt = FAULT;
        end
      end
      MEM_RD: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          mdr_ld = 1'b1;
          st_nxt = WB_MEM;
        end else if (wait_exp) begin
          st_nxt = FAULT;
        end
      end
      MEM_WR: begin
        mem_wr = 1'b1;
        if (mem_rdy) begin
          st_nxt = st_done;
        end else if (wait_exp) begin
          st_nxt = FAULT;
        end
      end
      WB_ALU, WB_MEM: begin
        rf_we  = 1'b1;
        st_nxt = st_done;
      end
      BRANCH: begin
        if (zero) begin
          pc_ld  = 1'b1;
          pc_src = PC_BRANCH;
        end
        st_nxt = st_done;
      end
      JUMP: begin
        pc_ld  = 1'b1;
        pc_src = PC_JUMP;
        st_nxt = st_done;
      end
`ifdef INTR_EN
      INTR: begin
        epc_ld  = 1'b1;
        int_ack = 1'b1;
        pc_ld   = 1'b1;
        pc_src  = INT_VEC_SEL;
        st_nxt  = FETCH;
      end
`endif
      FAULT:   st_nxt = FAULT;
      default: st_nxt = FAULT;
    endcase

    // No datapath side effects while reset is held.
    if (RESET) begin
      pc_ld     = 1'b0;
      ir_ld     = 1'b0;
      mdr_ld    = 1'b0;
      aluout_ld = 1'b0;
      rf_we     = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      epc_ld    = 1'b0;
      int_ack   = 1'b0;
      pc_src    = PC_INC;
    end
  end

  assign state = st;
  assign fault = (st == FAULT);

endmodule

// File: tb/tb_ld_sequencer.sv
// Directed testbench for ld_sequencer with a queue-based scoreboard.
// Stimulus pushes the hand-computed output vector expected for each driven
// cycle; the monitor pops and compares on the falling edge.
module tb_ld_sequencer;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1, S_EXEC_R = 4'd2,
                         S_EXEC_I = 4'd3, S_MEM_ADDR = 4'd4, S_MEM_RD = 4'd5,
                         S_MEM_WR = 4'd6, S_WB_ALU = 4'd7, S_WB_MEM = 4'd8,
                         S_BRANCH = 4'd9, S_JUMP = 4'd10, S_INTR = 4'd11,
                         S_FAULT = 4'd12;

  // Enable bit order: pc, ir, mdr, alu, rf, mem_rd, mem_wr, epc, ack
  localparam logic [8:0] E_PC  = 9'h100, E_IR  = 9'h080, E_MDR = 9'h040,
                         E_ALU = 9'h020, E_RF  = 9'h010, E_MRD = 9'h008,
                         E_MWR = 9'h004, E_EPC = 9'h002, E_ACK = 9'h001,
                         E_NONE = 9'h000;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [5:0] opcode;
  logic       zero, mem_rdy, int_req;
  logic       pc_ld, ir_ld, mdr_ld, aluout_ld, rf_we, mem_rd, mem_wr;
  logic       epc_ld, int_ack, fault;
  logic [1:0] pc_src;
  logic [3:0] state;

  always #5 CLK = ~CLK;

  ld_sequencer #(.WAIT_MAX(15), .INT_VEC_SEL(2'b11)) dut (
    .CLK(CLK), .RESET(RESET), .opcode(opcode), .zero(zero),
    .mem_rdy(mem_rdy), .int_req(int_req),
    .pc_ld(pc_ld), .ir_ld(ir_ld), .mdr_ld(mdr_ld), .aluout_ld(aluout_ld),
    .rf_we(rf_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .epc_ld(epc_ld),
    .int_ack(int_ack), .pc_src(pc_src), .state(state), .fault(fault)
  );

  logic [15:0] act;
  assign act = {state, pc_ld, ir_ld, mdr_ld, aluout_ld, rf_we, mem_rd, mem_wr,
                epc_ld, int_ack, pc_src, fault};

  logic [15:0] exp_q[$];
  string       nm_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] mk(input logic [3:0] st, input logic [8:0] en,
                                     input logic [1:0] src, input logic flt);
    return {st, en, src, flt};
  endfunction

  // Monitor: compare whatever expectation is pending for this cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      automatic logic [15:0] e = exp_q.pop_front();
      automatic string       n = nm_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
                 n, act[15:12], act, e[15:12], e);
      end
    end
  end

  task automatic step(input string n, input logic [5:0] op, input logic z,
                      input logic rdy, input logic irq, input logic rs,
                      input logic chk, input logic [15:0] e);
    opcode  = op;
    zero    = z;
    mem_rdy = rdy;
    int_req = irq;
    RESET   = rs;
    if (chk) begin
      exp_q.push_back(e);
      nm_q.push_back(n);
    end
    @(posedge CLK);
    #1;
  endtask

  localparam logic [15:0] X_FETCH_OK = {S_FETCH, E_MRD | E_IR | E_PC, 2'd0, 1'b0};
  localparam logic [15:0] X_FETCH_WT = {S_FETCH, E_MRD, 2'd0, 1'b0};

  initial begin
    RESET = 1'b1; opcode = '0; zero = 1'b0; mem_rdy = 1'b0; int_req = 1'b0;
    step("por", 6'h00, 0, 0, 0, 1, 0, 16'h0);
    step("reset_state", 6'h00, 0, 1, 0, 1, 1, mk(S_FETCH, E_NONE, 0, 0));

    // R-type: FETCH, DECODE, EXEC_R, WB_ALU
    step("r_fetch",  6'h00, 0, 1, 0, 0, 1, X_FETCH_OK);
    step("r_decode", 6'h00, 0, 1, 0, 0, 1, mk(S_DECODE, E_NONE, 0, 0));
    step("r_exec",   6'h00, 0, 1, 0, 0, 1, mk(S_EXEC_R, E_ALU, 0, 0));
    step("r_wb",     6'h00, 0, 1, 0, 0, 1, mk(S_WB_ALU, E_RF, 0, 0));

    // ADDI
    step("i_fetch",  6'h08, 0, 1, 0, 0, 1, X_FETCH_OK);
    step("i_decode", 6'h08, 0, 1, 0, 0, 1, mk(S_DECODE, E_NONE, 0, 0));
    step("i_exec",   6'h08, 0, 1, 0, 0, 1, mk(S_EXEC_I, E_ALU, 0, 0));
    step("i_wb",     6'h08, 0, 1, 0, 0, 1, mk(S_WB_ALU, E_RF, 0, 0));

    // LW with three wait cycles in MEM_RD: 8 cycles total
    step("lw_fetch", 6'h23, 0, 1, 0, 0, 1, X_FETCH_OK);
    step("lw_decode",6'h23, 0, 1, 0, 0, 1, mk(S_DECODE, E_NONE, 0, 0));
    step("lw_addr",  6'h23, 0, 1, 0, 0, 1, mk(S_MEM_ADDR, E_ALU, 0, 0));
    for (int k = 0; k < 3; k++)
      step("lw_wait", 6'h23, 0, 0, 0, 0, 1, mk(S_MEM_RD, E_MRD, 0, 0));
    step("lw_rdy",   6'h23, 0, 1, 0, 0, 1, mk(S_MEM_RD, E_MRD | E_MDR, 0, 0));
    step("lw_wb",    6'h23, 0, 1, 0, 0, 1, mk(S_WB_MEM, E_RF, 0, 0));

    // SW with one wait cycle
    step("sw_fetch", 6'h2B, 0, 1, 0, 0, 1, X_FETCH_OK);
    step("sw_decode",6'h2B, 0, 1, 0, 0, 1, mk(S_DECODE, E_NONE, 0, 0));
    step("sw_addr",  6'h2B, 0, 1, 0, 0, 1, mk(S_MEM_ADDR, E_ALU, 0, 0));
    step("sw_wait",  6'h2B, 0, 0, 0, 0, 1, mk(S_MEM_WR, E_MWR, 0, 0));
    step("sw_rdy",   6'h2B, 0, 1, 0, 0, 1, mk(S_MEM_WR, E_MWR, 0, 0));

    // BEQ taken, then not taken
    step("beq1_fetch", 6'h04, 1, 1, 0, 0, 1, X_FETCH_OK);
    step("beq1_decode",6'h04, 1, 1, 0, 0, 1, mk(S_DECODE, E_NONE, 0, 0));
    step("beq1_taken", 6'h04, 1, 1, 0, 0, 1, mk(S_BRANCH, E_PC, 2'd1, 0));
    step("beq0_fetch", 6'h04, 0, 1, 0, 0, 1, X_FETCH_OK);
    step("beq0_decode",6'h04, 0, 1, 0, 0, 1, mk(S_DECODE, E_NONE, 0, 0));
    step("beq0_nottk", 6'h04, 0, 1, 0, 0, 1, mk(S_BRANCH, E_NONE, 2'd0, 0));

    // Jump
    step("j_fetch",  6'h02, 0, 1, 0, 0, 1, X_FETCH_OK);
    step("j_decode", 6'h02, 0, 1, 0, 0, 1, mk(S_DECODE, E_NONE, 0, 0));
    step("j_jump",   6'h02, 0, 1, 0, 0, 1, mk(S_JUMP, E_PC, 2'd2, 0));

    // Interrupt requested throughout an R-type; only the WB_ALU exit samples it
    step("irq_fetch",  6'h00, 0, 1, 1, 0, 1, X_FETCH_OK);
    step("irq_decode", 6'h00, 0, 1, 1, 0, 1, mk(S_DECODE, E_NONE, 0, 0));
    step("irq_exec",   6'h00, 0, 1, 1, 0, 1, mk(S_EXEC_R, E_ALU, 0, 0));
    step("irq_wb",     6'h00, 0, 1, 1, 0, 1, mk(S_WB_ALU, E_RF, 0, 0));
`ifdef INTR_EN
    step("irq_intr",   6'h00, 0, 1, 1, 0, 1,
         mk(S_INTR, E_PC | E_EPC | E_ACK, 2'd3, 0));
`else
    step("irq_ignored",6'h00, 0, 0, 1, 0, 1, X_FETCH_WT);
`endif

    // Illegal opcode -> FAULT, sticky until reset; mem_rdy ignored there
    step("bad_fetch",  6'h3F, 0, 1, 0, 0, 1, X_FETCH_OK);
    step("bad_decode", 6'h3F, 0, 1, 0, 0, 1, mk(S_DECODE, E_NONE, 0, 0));
    step("bad_fault",  6'h3F, 0, 1, 0, 0, 1, mk(S_FAULT, E_NONE, 0, 1));
    step("bad_sticky", 6'h3F, 1, 1, 1, 0, 1, mk(S_FAULT, E_NONE, 0, 1));
    step("bad_rst",    6'h3F, 0, 1, 0, 1, 1, mk(S_FAULT, E_NONE, 0, 1));
    step("bad_clear",  6'h00, 0, 0, 0, 0, 1, X_FETCH_WT);

    // Timeout: that was wait 1; 14 more waits stay in FETCH, then FAULT
    for (int k = 0; k < 14; k++)
      step("to_wait", 6'h00, 0, 0, 0, 0, 1, X_FETCH_WT);
    step("to_fault",  6'h00, 0, 0, 0, 0, 1, mk(S_FAULT, E_NONE, 0, 1));
    step("to_rst",    6'h00, 0, 0, 0, 1, 1, mk(S_FAULT, E_NONE, 0, 1));

    // Reset mid-wait at cycle 7 must restart the full 15-cycle budget
    for (int k = 0; k < 6; k++)
      step("mid_wait", 6'h00, 0, 0, 0, 0, 1, X_FETCH_WT);
    step("mid_rst",   6'h00, 0, 0, 0, 1, 1, mk(S_FETCH, E_NONE, 0, 0));
    for (int k = 0; k < 15; k++)
      step("mid_rewait", 6'h00, 0, 0, 0, 0, 1, X_FETCH_WT);
    step("mid_fault", 6'h00, 0, 0, 0, 0, 1, mk(S_FAULT, E_NONE, 0, 1));
    step("end_rst",   6'h00, 0, 0, 0, 1, 0, 16'h0);

    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
